// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-master round-robin arbiter onto a shared register bus.
// Each access is a write (wr strobe, then done) or a read (rd strobe, then wait
// for reg_rd_done, then done). All outputs are registered.
//
// Optional feature: define REG_ARB_TIMEOUT_EN to compile in a read-wait timeout.
// After TIMEOUT_CYCLES cycles in WAIT_RD without reg_rd_done, the read completes
// with RD_ERR_DATA and the err flag set. Without the macro, WAIT_RD waits forever.
//
// state   | meaning
// IDLE    | no access; arbitrate between pending requests
// ISSUE   | gnt pulse and the wr/rd strobe are on the bus this cycle
// WAIT_RD | read issued; waiting for reg_rd_done (or the timeout)
// DONE    | done pulse to the owner; return to IDLE next cycle
module reg_bus_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [31:0] RD_ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        core_clk,
  input  logic        core_rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [7:0]  m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [7:0]  m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wr_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rd_data,
  input  logic        reg_rd_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

  state_t      state, state_d;
  logic        owner, owner_d;       // 0 = m0 owns the access in flight, 1 = m1
  logic        we_q, we_d;
  logic        last_m1, last_m1_d;   // 1 = m1 was granted most recently
  logic        pick_m1;
  logic [1:0]  gnt_d, done_d, err_d;
  logic [31:0] rdata0_d, rdata1_d;
  logic [7:0]  addr_d;
  logic [31:0] wdata_d;
  logic        wr_en_d, rd_en_d;

`ifdef REG_ARB_TIMEOUT_EN
  logic [15:0] cnt, cnt_d;
`else
  logic        unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, RD_ERR_DATA};
`endif

  // Next-state and next-output computation; everything lands in registers below.
  always_comb begin
    state_d   = state;
    owner_d   = owner;
    we_d      = we_q;
    last_m1_d = last_m1;
    pick_m1   = 1'b0;
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    err_d     = {m1_err, m0_err};
    rdata0_d  = m0_rdata;
    rdata1_d  = m1_rdata;
    addr_d    = reg_addr;
    wdata_d   = reg_wr_data;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
    cnt_d     = cnt;
`endif
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master that was not granted last wins.
          pick_m1   = m1_req && (!m0_req || !last_m1);
          owner_d   = pick_m1;
          last_m1_d = pick_m1;
          we_d      = pick_m1 ? m1_we : m0_we;
          addr_d    = pick_m1 ? m1_addr : m0_addr;
          wdata_d   = pick_m1 ? m1_wdata : m0_wdata;
          gnt_d     = pick_m1 ? 2'b10 : 2'b01;
          wr_en_d   = we_d;
          rd_en_d   = !we_d;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          done_d       = owner ? 2'b10 : 2'b01;
          err_d[owner] = 1'b0;
          state_d      = DONE;
        end else begin
`ifdef REG_ARB_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
          state_d = WAIT_RD;
        end
      end
      WAIT_RD: begin
        // A completion in the same cycle as the timeout takes priority.
        if (reg_rd_done) begin
          if (owner) rdata1_d = reg_rd_data;
          else       rdata0_d = reg_rd_data;
          err_d[owner] = 1'b0;
          done_d       = owner ? 2'b10 : 2'b01;
          state_d      = DONE;
        end
`ifdef REG_ARB_TIMEOUT_EN
        else if (cnt == TIMEOUT_CYCLES - 16'd1) begin
          if (owner) rdata1_d = RD_ERR_DATA;
          else       rdata0_d = RD_ERR_DATA;
          err_d[owner] = 1'b1;
          done_d       = owner ? 2'b10 : 2'b01;
          state_d      = DONE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      last_m1     <= 1'b1;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      m0_done     <= 1'b0;
      m1_done     <= 1'b0;
      m0_err      <= 1'b0;
      m1_err      <= 1'b0;
      m0_rdata    <= 32'h0;
      m1_rdata    <= 32'h0;
      reg_addr    <= 8'h0;
      reg_wr_data <= 32'h0;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
      cnt         <= 16'd0;
`endif
    end else begin
      state       <= state_d;
      owner       <= owner_d;
      we_q        <= we_d;
      last_m1     <= last_m1_d;
      m0_gnt      <= gnt_d[0];
      m1_gnt      <= gnt_d[1];
      m0_done     <= done_d[0];
      m1_done     <= done_d[1];
      m0_err      <= err_d[0];
      m1_err      <= err_d[1];
      m0_rdata    <= rdata0_d;
      m1_rdata    <= rdata1_d;
      reg_addr    <= addr_d;
      reg_wr_data <= wdata_d;
      reg_wr_en   <= wr_en_d;
      reg_rd_en   <= rd_en_d;
      busy        <= (state_d != IDLE);
`ifdef REG_ARB_TIMEOUT_EN
      cnt         <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter: scenario tasks with a scoreboard of expected
// completions, a register-target model with programmable read latency, and a
// bus monitor counting strobes, grants and done pulses.
module tb_reg_bus_arbiter;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b1;
  logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [7:0]  m0_addr = 8'h0, m1_addr = 8'h0;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en, reg_rd_en, busy;
  logic [31:0] reg_rd_data = 32'h0;
  logic        reg_rd_done = 1'b0;

  reg_bus_arbiter #(.TIMEOUT_CYCLES(16'd8), .RD_ERR_DATA(32'hDEAD_BEEF)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
    .reg_rd_data(reg_rd_data), .reg_rd_done(reg_rd_done), .busy(busy)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    bit          mst;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   gnt_order_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tgt_lat = 0;
  logic [31:0] tgt_data = 32'h0;
  int   pend = 0;
  int   dual_gnt = 0, dual_strobe = 0, m1_gnt_cnt = 0, m0_done_cnt = 0;
  int   rd_en_cnt = 0, wr_en_cnt = 0;

  always @(posedge core_clk) cyc++;

  // Target: answers each read strobe tgt_lat cycles later (never if tgt_lat <= 0).
  always @(posedge core_clk) begin
    #2;
    reg_rd_done = 1'b0;
    reg_rd_data = 32'h0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        reg_rd_done = 1'b1;
        reg_rd_data = tgt_data;
      end
    end
    if (reg_rd_en === 1'b1 && tgt_lat > 0) pend = tgt_lat;
  end

  // Monitor: counts the previous cycle's output pulses.
  always @(posedge core_clk) begin
    if (m0_gnt === 1'b1 && m1_gnt === 1'b1) dual_gnt++;
    if (reg_wr_en === 1'b1 && reg_rd_en === 1'b1) dual_strobe++;
    if (m1_gnt === 1'b1) m1_gnt_cnt++;
    if (m0_done === 1'b1) m0_done_cnt++;
    if (reg_rd_en === 1'b1) rd_en_cnt++;
    if (reg_wr_en === 1'b1) wr_en_cnt++;
  end

  task automatic do_reset();
    @(negedge core_clk);
    core_rst_n = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) @(negedge core_clk);
    core_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2 core_rst_n = 1'b0;
    @(negedge core_clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if ({m1_gnt, m0_gnt} !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b expected 00", {m1_gnt, m0_gnt}); end
    vectors++; if ({m1_done, m0_done, m1_err, m0_err} !== 4'b0) begin miscompares++; $display("FAIL reset_done_err: got %b expected 0000", {m1_done, m0_done, m1_err, m0_err}); end
    vectors++; if ({reg_wr_en, reg_rd_en} !== 2'b00) begin miscompares++; $display("FAIL reset_strobes: got %b expected 00", {reg_wr_en, reg_rd_en}); end
    vectors++; if (reg_addr !== 8'h0 || reg_wr_data !== 32'h0) begin miscompares++; $display("FAIL reset_bus: got addr %h data %h expected 0", reg_addr, reg_wr_data); end
    vectors++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h %h expected 0", m0_rdata, m1_rdata); end
    @(negedge core_clk);
    core_rst_n = 1'b1;
  endtask

  task automatic test_write();
    exp_t e;
    int   rd0;
    rd0 = rd_en_cnt;
    @(negedge core_clk);
    m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 32'h1234_5678; m0_req = 1'b1;
    exp_q.push_back('{mst: 1'b0, rdata: 32'h0, err: 1'b0});
    @(negedge core_clk);
    vectors++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin miscompares++; $display("FAIL wr_gnt: got m0 %b m1 %b expected 1 0", m0_gnt, m1_gnt); end
    vectors++; if (reg_wr_en !== 1'b1 || reg_rd_en !== 1'b0) begin miscompares++; $display("FAIL wr_strobe: got wr %b rd %b expected 1 0", reg_wr_en, reg_rd_en); end
    vectors++; if (reg_addr !== 8'h10 || reg_wr_data !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_bus: got %h %h expected 10 12345678", reg_addr, reg_wr_data); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b expected 1", busy); end
    @(negedge core_clk);
    vectors++; if (m0_done !== 1'b1) begin miscompares++; $display("FAIL wr_done_latency: got %b expected 1", m0_done); end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++; if (m0_err !== e.err || m0_rdata !== e.rdata) begin miscompares++; $display("FAIL wr_result: got err %b rdata %h expected %b %h", m0_err, m0_rdata, e.err, e.rdata); end
    end
    m0_req = 1'b0;
    @(negedge core_clk);
    vectors++; if (m0_done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL wr_after: got done %b busy %b expected 0 0", m0_done, busy); end
    vectors++; if (reg_addr !== 8'h10 || reg_wr_data !== 32'h1234_5678) begin miscompares++; $display("FAIL wr_hold: got %h %h expected 10 12345678", reg_addr, reg_wr_data); end
    vectors++; if (rd_en_cnt != rd0) begin miscompares++; $display("FAIL wr_no_rd: got %0d rd strobes expected 0", rd_en_cnt - rd0); end
  endtask

  task automatic test_read();
    exp_t e;
    int   rd_en_cyc = -1, rd_done_cyc = -1, done_cyc = -1, rd0, wr0;
    logic [7:0] addr_seen = 8'h0;
    logic [31:0] got_rdata = 32'h0;
    logic got_err = 1'b0;
    rd0 = rd_en_cnt; wr0 = wr_en_cnt;
    tgt_lat = 3; tgt_data = 32'hCAFE_0001;
    @(negedge core_clk);
    m1_we = 1'b0; m1_addr = 8'h22; m1_wdata = 32'h0; m1_req = 1'b1;
    exp_q.push_back('{mst: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0});
    for (int i = 0; i < 20 && done_cyc < 0; i++) begin
      @(negedge core_clk);
      if (reg_rd_en === 1'b1) begin rd_en_cyc = cyc; addr_seen = reg_addr; end
      if (reg_rd_done === 1'b1) rd_done_cyc = cyc;
      if (m1_done === 1'b1) begin done_cyc = cyc; got_rdata = m1_rdata; got_err = m1_err; m1_req = 1'b0; end
    end
    m1_req = 1'b0;
    vectors++;
    if (done_cyc < 0) begin
      miscompares++; $display("FAIL rd_timeout: got no m1_done in 20 cycles expected done");
      exp_q.delete();
    end else begin
      if (done_cyc != rd_done_cyc + 1) begin miscompares++; $display("FAIL rd_done_timing: got done cycle %0d expected %0d", done_cyc, rd_done_cyc + 1); end
      e = exp_q.pop_front();
      vectors++; if (got_rdata !== e.rdata || got_err !== e.err) begin miscompares++; $display("FAIL rd_result: got %h err %b expected %h err %b", got_rdata, got_err, e.rdata, e.err); end
    end
    vectors++; if (addr_seen !== 8'h22 || rd_en_cyc < 0) begin miscompares++; $display("FAIL rd_addr: got %h expected 22", addr_seen); end
    repeat (2) @(negedge core_clk);
    vectors++; if (rd_en_cnt - rd0 != 1 || wr_en_cnt != wr0) begin miscompares++; $display("FAIL rd_strobes: got rd %0d wr %0d expected 1 0", rd_en_cnt - rd0, wr_en_cnt - wr0); end
    vectors++; if (m1_rdata !== 32'hCAFE_0001 || m0_rdata !== 32'h0) begin miscompares++; $display("FAIL rd_hold: got m1 %h m0 %h expected cafe0001 0", m1_rdata, m0_rdata); end
  endtask

  task automatic test_round_robin();
    int n = 0, exp_m, got_m, d0;
    do_reset();
    d0 = dual_gnt;
    gnt_order_q.delete();
    gnt_order_q.push_back(0); gnt_order_q.push_back(1);
    gnt_order_q.push_back(0); gnt_order_q.push_back(1);
    @(negedge core_clk);
    m0_we = 1'b1; m0_addr = 8'h30; m0_wdata = 32'h0000_0030; m0_req = 1'b1;
    m1_we = 1'b1; m1_addr = 8'h31; m1_wdata = 32'h0000_0031; m1_req = 1'b1;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge core_clk);
      if (m0_gnt === 1'b1 || m1_gnt === 1'b1) begin
        exp_m = gnt_order_q.pop_front();
        got_m = (m1_gnt === 1'b1) ? 1 : 0;
        vectors++; if (got_m != exp_m) begin miscompares++; $display("FAIL rr_order_%0d: got m%0d expected m%0d", n, got_m, exp_m); end
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    vectors++; if (n != 4) begin miscompares++; $display("FAIL rr_count: got %0d grants expected 4", n); end
    repeat (5) @(negedge core_clk);
    vectors++; if (dual_gnt != d0) begin miscompares++; $display("FAIL rr_dual_gnt: got %0d expected 0", dual_gnt - d0); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int g1 = -1, g2 = -1, dones = 0;
    @(negedge core_clk);
    m0_we = 1'b1; m0_addr = 8'h44; m0_wdata = 32'h0BAD_F00D; m0_req = 1'b1;
    exp_q.push_back('{mst: 1'b0, rdata: 32'h0, err: 1'b0});
    exp_q.push_back('{mst: 1'b0, rdata: 32'h0, err: 1'b0});
    for (int i = 0; i < 20 && dones < 2; i++) begin
      @(negedge core_clk);
      if (m0_gnt === 1'b1) begin if (g1 < 0) g1 = cyc; else begin g2 = cyc; m0_req = 1'b0; end end
      if (m0_done === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        dones++;
        vectors++; if (m0_err !== e.err) begin miscompares++; $display("FAIL b2b_err_%0d: got %b expected %b", dones, m0_err, e.err); end
      end
    end
    m0_req = 1'b0;
    exp_q.delete();
    vectors++; if (g2 - g1 != 3 || g1 < 0) begin miscompares++; $display("FAIL b2b_spacing: got %0d cycles expected 3", g2 - g1); end
    vectors++; if (dones != 2) begin miscompares++; $display("FAIL b2b_dones: got %0d expected 2", dones); end
    @(negedge core_clk);
  endtask

  task automatic test_req_drop();
    exp_t e;
    int   g1, done_seen = 0;
    g1 = m1_gnt_cnt;
    tgt_lat = 6; tgt_data = 32'hA5A5_0003;
    @(negedge core_clk);
    m0_we = 1'b0; m0_addr = 8'h40; m0_req = 1'b1;
    exp_q.push_back('{mst: 1'b0, rdata: 32'hA5A5_0003, err: 1'b0});
    @(negedge core_clk);
    vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL drop_gnt: got %b expected 1", m0_gnt); end
    m0_req = 1'b0;
    m1_we = 1'b1; m1_addr = 8'h41; m1_req = 1'b1;
    @(negedge core_clk);
    m1_req = 1'b0;
    for (int i = 0; i < 20 && done_seen == 0; i++) begin
      @(negedge core_clk);
      if (m0_done === 1'b1) begin
        done_seen = 1;
        e = exp_q.pop_front();
        vectors++; if (m0_rdata !== e.rdata || m0_err !== e.err) begin miscompares++; $display("FAIL drop_result: got %h err %b expected %h err %b", m0_rdata, m0_err, e.rdata, e.err); end
      end
    end
    vectors++; if (done_seen == 0) begin miscompares++; $display("FAIL drop_done: got no m0_done expected done"); exp_q.delete(); end
    repeat (5) @(negedge core_clk);
    vectors++; if (m1_gnt_cnt != g1) begin miscompares++; $display("FAIL drop_m1_gnt: got %0d grants expected 0", m1_gnt_cnt - g1); end
  endtask

  task automatic test_reset_mid();
    int d0;
    tgt_lat = 5; tgt_data = 32'h1111_2222;
    @(negedge core_clk);
    m0_we = 1'b0; m0_addr = 8'h50; m0_req = 1'b1;
    @(negedge core_clk);
    m0_req = 1'b0;
    @(negedge core_clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_pre: got %b expected 1", busy); end
    d0 = m0_done_cnt;
    core_rst_n = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || m0_done !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got busy %b done %b expected 0 0", busy, m0_done); end
    @(negedge core_clk);
    core_rst_n = 1'b1;
    repeat (8) @(negedge core_clk);
    vectors++; if (m0_done_cnt != d0) begin miscompares++; $display("FAIL rstmid_no_done: got %0d done pulses expected 0", m0_done_cnt - d0); end
    vectors++; if (m0_rdata !== 32'h0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_late_rd: got rdata %h busy %b expected 0 0", m0_rdata, busy); end
    m1_we = 1'b1; m1_addr = 8'h60; m1_wdata = 32'h6060_6060; m1_req = 1'b1;
    @(negedge core_clk);
    vectors++; if (m1_gnt !== 1'b1 || reg_wr_en !== 1'b1 || reg_addr !== 8'h60) begin miscompares++; $display("FAIL rstmid_m1_gnt: got gnt %b wr %b addr %h expected 1 1 60", m1_gnt, reg_wr_en, reg_addr); end
    @(negedge core_clk);
    vectors++; if (m1_done !== 1'b1) begin miscompares++; $display("FAIL rstmid_m1_done: got %b expected 1", m1_done); end
    m1_req = 1'b0;
    @(negedge core_clk);
  endtask

  task automatic test_read_wait(input int lat, input logic [31:0] data, input int exp_off,
                                input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   rd_en_cyc = -1, done_cyc = -1, d0;
    logic [31:0] got_rd = 32'h0;
    logic got_err = 1'b0;
    tgt_lat = lat; tgt_data = data;
    @(negedge core_clk);
    m0_we = 1'b0; m0_addr = 8'h70; m0_req = 1'b1;
    d0 = m0_done_cnt;
    exp_q.push_back('{mst: 1'b0, rdata: exp_rd, err: exp_err});
    for (int i = 0; i < 60 && done_cyc < 0; i++) begin
      @(negedge core_clk);
      if (reg_rd_en === 1'b1) begin rd_en_cyc = cyc; m0_req = 1'b0; end
      if (m0_done === 1'b1) begin done_cyc = cyc; got_rd = m0_rdata; got_err = m0_err; end
    end
    m0_req = 1'b0;
    vectors++;
    if (done_cyc < 0) begin
      miscompares++; $display("FAIL wait_lat%0d_timeout: got no m0_done in 60 cycles expected done", lat);
      exp_q.delete();
    end else begin
      if (done_cyc - rd_en_cyc != exp_off) begin miscompares++; $display("FAIL wait_lat%0d_latency: got %0d expected %0d", lat, done_cyc - rd_en_cyc, exp_off); end
      e = exp_q.pop_front();
      vectors++; if (got_rd !== e.rdata || got_err !== e.err) begin miscompares++; $display("FAIL wait_lat%0d_result: got %h err %b expected %h err %b", lat, got_rd, got_err, e.rdata, e.err); end
    end
    repeat (lat + 4) @(negedge core_clk);
    vectors++; if (m0_rdata !== exp_rd || m0_done_cnt - d0 != 1 || busy !== 1'b0) begin miscompares++; $display("FAIL wait_lat%0d_after: got rdata %h dones %0d busy %b expected %h 1 0", lat, m0_rdata, m0_done_cnt - d0, busy, exp_rd); end
  endtask

  task automatic test_invariants();
    vectors++; if (dual_strobe != 0) begin miscompares++; $display("FAIL both_strobes: got %0d cycles expected 0", dual_strobe); end
    vectors++; if (dual_gnt != 0) begin miscompares++; $display("FAIL both_gnt: got %0d cycles expected 0", dual_gnt); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_req_drop();
    test_reset_mid();
`ifdef REG_ARB_TIMEOUT_EN
    test_read_wait(12, 32'h7777_0012, 9, 32'hDEAD_BEEF, 1'b1);
    test_read_wait(8,  32'h7777_0008, 9, 32'h7777_0008, 1'b0);
`else
    test_read_wait(30, 32'h7777_0030, 31, 32'h7777_0030, 1'b0);
`endif
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16'd1024, read-wait limit in core_clk cycles; legal range 1..65535.
REQ-002 Parameter RD_ERR_DATA, default 32'hDEAD_BEEF, read data returned on timeout.
REQ-003 core_clk  input  1  single clock; all state on its rising edge.
REQ-004 core_rst_n  input  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  input  1  requester N access request; held high until mN_done.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read; stable while mN_req high.
REQ-007 m0_addr / m1_addr  input  8  register address.
REQ-008 m0_wdata / m1_wdata  input  32  write data.
REQ-009 m0_gnt / m1_gnt  output  1  one-cycle pulse: request accepted.
REQ-010 m0_done / m1_done  output  1  one-cycle pulse: access complete.
REQ-011 m0_rdata / m1_rdata  output  32  read data; valid in the mN_done cycle, held until the next read completion for that requester.
REQ-012 m0_err / m1_err  output  1  read timed out; valid with mN_done.
REQ-013 reg_addr  output  8  shared register-bus address.
REQ-014 reg_wr_data  output  32  shared register-bus write data.
REQ-015 reg_wr_en / reg_rd_en  output  1  one-cycle write/read strobes.
REQ-016 reg_rd_data  input  32  target read data, valid with reg_rd_done.
REQ-017 reg_rd_done  input  1  target read completion pulse.
REQ-018 busy  output  1  high whenever state != IDLE.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT_RD, DONE; all outputs registered.
REQ-020 IDLE: a single requesting master is granted; on a tie, the master not granted last wins; otherwise stay IDLE.
REQ-021 On grant: next cycle state=ISSUE, mN_gnt=1, address/we/wdata latched onto reg_addr and reg_wr_data, and in the same cycle reg_wr_en=we or reg_rd_en=!we.
REQ-022 ISSUE -> DONE for a write; ISSUE -> WAIT_RD for a read.
REQ-023 WAIT_RD: on reg_rd_done, capture reg_rd_data into mN_rdata, set mN_err=0, go to DONE.
REQ-024 DONE: mN_done=1 for exactly one cycle, then IDLE; write latency from req to done is 2 cycles.
REQ-025 reg_rd_done in IDLE, ISSUE or DONE is ignored.
REQ-026 A request that drops before grant is dropped silently; a request that drops after grant does not abort the access.
REQ-027 A request still high in the cycle after mN_done is treated as a new request.
REQ-028 reg_addr and reg_wr_data hold their last granted values between accesses.
REQ-029 Only one reg_wr_en or reg_rd_en pulse is issued per grant; never both.

Reset
REQ-030 Asserting core_rst_n low at any time, including mid-access, forces IDLE asynchronously.
REQ-031 Reset values: all gnt, done, err, wr_en, rd_en and busy = 0; reg_addr = 0; reg_wr_data = 0; rdata = 0; round-robin pointer = "m1 last", so m0 wins the first tie.
REQ-032 An access in flight at reset produces no done pulse; a late reg_rd_done is ignored.

Configuration
REQ-033 Macro REG_ARB_TIMEOUT_EN compiled in: a 16-bit counter clears on entry to WAIT_RD and increments each WAIT_RD cycle.
REQ-034 With REG_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES without reg_rd_done: mN_rdata=RD_ERR_DATA, mN_err=1, go to DONE.
REQ-035 With REG_ARB_TIMEOUT_EN, reg_rd_done in the same cycle as the timeout wins: capture the data and set err=0.
REQ-036 Without REG_ARB_TIMEOUT_EN: no counter, WAIT_RD waits indefinitely, and mN_err stays 0.

Verification
REQ-037 m0 write addr 8'h10 data 32'h1234_5678 -> reg_wr_en pulse with that addr/data one cycle after req; m0_done two cycles after req; no reg_rd_en.
REQ-038 m1 read addr 8'h22, target returns 32'hCAFE_0001 three cycles after reg_rd_en -> m1_rdata=32'hCAFE_0001, m1_err=0, m1_done the cycle after reg_rd_done.
REQ-039 m0 and m1 both request from reset, repeatedly -> grant order m0, m1, m0, m1; never two gnt in one cycle.
REQ-040 With REG_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, read with no reg_rd_done -> m0_done with m0_err=1 and m0_rdata=32'hDEAD_BEEF; a later reg_rd_done is ignored.
REQ-041 core_rst_n pulsed low during WAIT_RD -> busy=0 immediately, no done pulse, and the next m1 request is granted normally.
